// File: rtl/axi_pkg.sv
// Shared AXI read-address types, widths and master tags for the AR arbiter slice.
// Width defaults come from the `AXI_* defines when the including build does not set them.
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif

package axi_pkg;

  localparam int ID_W    = `AXI_ID_BITS;
  localparam int TAG_W   = 4;
  localparam int IDS_W   = `AXI_IDS_BITS;
  localparam int ADDR_W  = `AXI_ADDR_BITS;
  localparam int LEN_W   = `AXI_LEN_BITS;
  localparam int SIZE_W  = `AXI_SIZE_BITS;
  localparam int BURST_W = 2;

  localparam logic [TAG_W-1:0] MASTER_TAG_M0 = 4'b0001;
  localparam logic [TAG_W-1:0] MASTER_TAG_M1 = 4'b0010;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic [IDS_W-1:0]   id;
    logic [ADDR_W-1:0]  addr;
    logic [LEN_W-1:0]   len;
    logic [SIZE_W-1:0]  size;
    logic [BURST_W-1:0] burst;
  } ar_payload_t;

endpackage

// File: rtl/ar_reg_slice.sv
// Two-entry skid register slice on ar_payload_t; full throughput, registered outputs.
// Used by ar_arbiter only when AXI_AR_REGSLICE_EN is defined.
module ar_reg_slice
  import axi_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  ar_payload_t in_data_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output ar_payload_t out_data_o
);

  logic        out_valid_q, out_valid_d;
  logic        skid_valid_q, skid_valid_d;
  ar_payload_t out_data_q, out_data_d;
  ar_payload_t skid_data_q, skid_data_d;
  logic        in_fire;

  // Ready depends only on the skid entry, so it never combinationally follows out_ready_i.
  assign in_ready_o  = ~skid_valid_q;
  assign in_fire     = in_valid_i & ~skid_valid_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (out_ready_i || !out_valid_q) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = in_fire;
        if (in_fire) begin
          out_data_d = in_data_i;
        end
      end
    end else if (in_fire) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_data_q   <= '0;
      skid_data_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      out_data_q   <= out_data_d;
      skid_data_q  <= skid_data_d;
    end
  end

endmodule

// File: rtl/ar_arbiter.sv
// Two-master AXI AR arbiter: round-robin tie-break, grant locked until handshake, ARID tagged.
// Define AXI_AR_REGSLICE_EN to register the output through ar_reg_slice (one cycle of latency).
module ar_arbiter
  import axi_pkg::*;
#(
  parameter int ID_W   = `AXI_ID_BITS,
  parameter int TAG_W  = 4,
  parameter int ADDR_W = `AXI_ADDR_BITS
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic [ID_W-1:0]         ARID_M0,
  input  logic [ADDR_W-1:0]       ARADDR_M0,
  input  logic [LEN_W-1:0]        ARLEN_M0,
  input  logic [SIZE_W-1:0]       ARSIZE_M0,
  input  logic [1:0]              ARBURST_M0,
  input  logic                    ARVALID_M0,
  output logic                    ARREADY_M0,
  input  logic [ID_W-1:0]         ARID_M1,
  input  logic [ADDR_W-1:0]       ARADDR_M1,
  input  logic [LEN_W-1:0]        ARLEN_M1,
  input  logic [SIZE_W-1:0]       ARSIZE_M1,
  input  logic [1:0]              ARBURST_M1,
  input  logic                    ARVALID_M1,
  output logic                    ARREADY_M1,
  output logic [ID_W+TAG_W-1:0]   ARID,
  output logic [ADDR_W-1:0]       ARADDR,
  output logic [LEN_W-1:0]        ARLEN,
  output logic [SIZE_W-1:0]       ARSIZE,
  output logic [1:0]              ARBURST,
  output logic                    ARVALID,
  input  logic                    ARREADY
);

  arb_state_e  state_q, state_d;
  logic        rr_q, rr_d;
  logic        gnt_q, gnt_d;
  logic        sel;
  logic        arb_valid;
  logic        acc_ready;
  logic        accept;
  ar_payload_t pl_m0, pl_m1, arb_pl, dn_pl;

  assign pl_m0 = '{id: {MASTER_TAG_M0, ARID_M0}, addr: ARADDR_M0, len: ARLEN_M0,
                   size: ARSIZE_M0, burst: ARBURST_M0};
  assign pl_m1 = '{id: {MASTER_TAG_M1, ARID_M1}, addr: ARADDR_M1, len: ARLEN_M1,
                   size: ARSIZE_M1, burst: ARBURST_M1};

  // Reset gates the request path so both master readies drop the moment ARESETn falls.
  always_comb begin
    sel       = rr_q;
    arb_valid = 1'b0;
    state_d   = state_q;
    rr_d      = rr_q;
    gnt_d     = gnt_q;
    case (state_q)
      IDLE: begin
        arb_valid = ARESETn & (ARVALID_M0 | ARVALID_M1);
        if (ARVALID_M0 && ARVALID_M1) begin
          sel = rr_q;
        end else begin
          sel = ARVALID_M1;
        end
        if (arb_valid) begin
          if (acc_ready) begin
            rr_d = ~sel;
          end else begin
            state_d = LOCK;
            gnt_d   = sel;
          end
        end
      end
      LOCK: begin
        sel       = gnt_q;
        arb_valid = ARESETn;
        if (acc_ready) begin
          rr_d    = ~gnt_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept     = arb_valid & acc_ready;
  assign ARREADY_M0 = accept & ~sel;
  assign ARREADY_M1 = accept & sel;
  assign arb_pl     = arb_valid ? (sel ? pl_m1 : pl_m0) : '0;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      gnt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
    end
  end

`ifdef AXI_AR_REGSLICE_EN
  ar_reg_slice u_ar_reg_slice (
    .clk_i      (ACLK),
    .rst_ni     (ARESETn),
    .in_valid_i (arb_valid),
    .in_ready_o (acc_ready),
    .in_data_i  (arb_pl),
    .out_valid_o(ARVALID),
    .out_ready_i(ARREADY),
    .out_data_o (dn_pl)
  );
`else
  assign acc_ready = ARREADY;
  assign ARVALID   = arb_valid;
  assign dn_pl     = arb_pl;
`endif

  assign ARID    = dn_pl.id;
  assign ARADDR  = dn_pl.addr;
  assign ARLEN   = dn_pl.len;
  assign ARSIZE  = dn_pl.size;
  assign ARBURST = dn_pl.burst;

endmodule

// File: doc/ar_arbiter.md
Name: ar_arbiter

Overview:
- Read-address-channel arbiter for the AXI interconnect; sits directly upstream of the AR address decoder.
- Arbitrates AR requests from masters M0 and M1 and forwards a single AR transaction to the decoder.
- Prepends a master tag to ARID so R responses can be routed back.
- Routes the downstream ARREADY back to the granted master only.

Parameters:
- ID_W, `AXI_ID_BITS (4): master-side ARID width.
- TAG_W, 4: master tag width; slave-side ID is ID_W+TAG_W = `AXI_IDS_BITS.
- ADDR_W, `AXI_ADDR_BITS (32): address width.

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  asynchronous active-low reset
- ARID_M0  in  ID_W  M0 read ID
- ARADDR_M0  in  ADDR_W  M0 address
- ARLEN_M0  in  `AXI_LEN_BITS  M0 burst length
- ARSIZE_M0  in  `AXI_SIZE_BITS  M0 beat size
- ARBURST_M0  in  2  M0 burst type
- ARVALID_M0  in  1  M0 request valid
- ARREADY_M0  out  1  M0 accept
- ARID_M1, ARADDR_M1, ARLEN_M1, ARSIZE_M1, ARBURST_M1, ARVALID_M1, ARREADY_M1: same as M0, for M1
- ARID  out  ID_W+TAG_W  {tag, master ID}; M0 tag 4'b0001, M1 tag 4'b0010
- ARADDR, ARLEN, ARSIZE, ARBURST  out  as master side  granted payload, to decoder
- ARVALID  out  1  granted request valid
- ARREADY  in  1  OR of selected slave ARREADY, returned from decoder side

Behaviour:
- State: FSM {IDLE, LOCK}, plus a 1-bit round-robin pointer rr (priority master) and a grant register gnt.
- Reset (ARESETn=0, async): state=IDLE, rr=M0, gnt=M0, ARVALID=0, ARREADY_M0=ARREADY_M1=0. Payload outputs are driven to 0.
- IDLE arbitration is combinational, so a grant costs zero cycles of latency:
  - Only one master valid: that master is selected.
  - Both valid: master rr is selected.
  - None valid: ARVALID=0.
- Selected payload drives the outputs in the same cycle; ARVALID=1.
- ARREADY_Mx = ARREADY & ARVALID & (sel==x). The non-granted master's ARREADY is always 0.
- Handshake in IDLE (ARREADY=1 in the same cycle): transfer completes; stay IDLE; rr=other master.
- No handshake in IDLE: go to LOCK and register gnt=sel.
- LOCK:
  - Output is muxed from gnt only; a new request from the other master is ignored. This guarantees AXI VALID/payload stability.
  - ARREADY=1 → handshake; rr=~gnt; go to IDLE. The next arbitration happens in the following cycle, so back-to-back grants are possible with no bubble.
- A master dropping ARVALID before its handshake is a protocol violation; behaviour is unspecified (no checking logic).
- Fairness: with both masters continuously valid, grants strictly alternate M0, M1, M0, ...
- ARID = {tag[3:0], ARID_Mx}; ARADDR/ARLEN/ARSIZE/ARBURST are passed unmodified.
- Reset asserted mid-LOCK: pending grant is discarded; both ARREADY_Mx=0 immediately. The master re-requests after reset.

Optional Feature:
- Macro: AXI_AR_REGSLICE_EN.
- Defined: a full-throughput 2-entry skid register slice is inserted between the arbiter output and the decoder.
  - ARVALID/payload reach the decoder 1 cycle after the grant.
  - The arbiter sees slice-ready (not ARREADY) as its accept.
  - Sustains 1 transfer/cycle.
  - Slice is empty after reset.
- Undefined: outputs are combinational from the arbiter as described above; zero latency.

Decomposition:
- Package axi_pkg:
  - ar_payload_t struct {id, addr, len, size, burst}
  - MASTER_TAG_M0/M1 constants
  - arb_state_e enum {IDLE, LOCK}
  - width localparams derived from `AXI_* defines
- Sub-module ar_reg_slice: generic valid/ready skid buffer on ar_payload_t, instantiated only under AXI_AR_REGSLICE_EN.

Test Plan:
- Single master: M0 ARVALID=1, ARADDR=32'h0000_1000, ARID=4'h3, ARREADY=1 → same cycle ARVALID=1, ARID=8'h13, ARREADY_M0=1, ARREADY_M1=0.
- Simultaneous requests: M0/M1 both valid after reset, ARREADY=1 held → grants M0, M1, M0, M1 on consecutive cycles; ARID tags 1,2,1,2.
- Backpressure: M1 granted with ARADDR=32'h0001_0004, ARREADY=0 for 5 cycles while M0 asserts → output payload stable with M1 tag; M0 granted the cycle after the M1 handshake.
- Reset mid-LOCK: ARESETn low during LOCK → ARVALID=0 and ARREADY_Mx=0 immediately; after release, rr=M0 and M0 wins a tie.
- No request: both ARVALID_Mx=0 for 10 cycles → ARVALID=0, state stays IDLE.
- With AXI_AR_REGSLICE_EN: continuous M0 stream with ARREADY=1 → first ARVALID one cycle after the request, then one transfer per cycle with no drops; toggling ARREADY causes no duplicate or lost addresses.
